seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Programmable Mealy serial-pattern detector. Supersedes the fixed 4-bit detector.
//   Pattern and length are runtime-configurable up to MAX_LEN bits.
//   Overlapping and non-overlapping detection are selectable.
//   Includes an input-enable qualifier, a saturating match counter and a registered match copy.
//   Sits on a 1-bit serial stream (line decoder / framing sync) beside the deserialiser.
// PARAMETERS
//   MAX_LEN  8  maximum pattern length in bits (>=2)
//   LEN_W    4  width of length field; must hold MAX_LEN
//   CNT_W    8  match counter width
// PORTS
//   clk          in   1         rising-edge clock
//   rst          in   1         asynchronous, active-low reset
//   cfg_load     in   1         latch cfg_pattern/cfg_len/cfg_overlap; flushes history
//   cfg_pattern  in   MAX_LEN   pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      in   LEN_W     pattern length; 0 = detector off; >MAX_LEN clamps to MAX_LEN
//   cfg_overlap  in   1         1 = overlapping matches allowed, 0 = non-overlapping
//   en           in   1         x is a valid sample this cycle
//   x            in   1         serial data bit
//   clr_count    in   1         synchronous clear of match_count and count_sat
//   match        out  1         Mealy: combinational, high in the cycle the last pattern bit is on x
//   match_q      out  1         match registered; one cycle after match
//   match_count  out  CNT_W     number of matches since reset/clear, saturating
//   count_sat    out  1         sticky: match_count reached all-ones
// BEHAVIOUR
//   Reset (rst=0, async):
//     - pat_r=0, len_r=0 (detector off), ovl_r=1, hist=0, fill=0.
//     - match_q=0, match_count=0, count_sat=0.
//     - match is forced 0 while rst=0.
//   Config:
//     - On cfg_load=1: registers take the new values at the next edge; fill=0; no match that cycle.
//     - cfg_load has priority over en.
//   History:
//     - hist is a MAX_LEN-bit shift register; hist[0] is the newest stored bit.
//     - fill counts stored valid bits, saturating at MAX_LEN.
//     - On en=1: hist <= {hist[MAX_LEN-2:0], x}; fill increments.
//     - On en=0: hist and fill hold; match=0.
//   Match condition (L = len_r):
//     - match = en & (L!=0) & (fill >= L-1) & ({hist[L-2:0], x} == pat_r[L-1:0]).
//     - For L=1: match = en & (x == pat_r[0]).
//     - Comparison is masked to L bits; unused pattern bits are ignored.
//   Overlap:
//     - ovl_r=1: history continues after a match.
//     - ovl_r=0: on match, fill <= 0 at the next edge; the matching bit is not reused.
//   Counter:
//     - On match, match_count increments, saturating at 2^CNT_W-1.
//     - On reaching 2^CNT_W-1, count_sat <= 1; it stays set until clr_count or reset.
//     - clr_count in the same cycle as match: clear wins (count=0, sat=0).
//     - clr_count does not affect history.
//   match_q <= match every clock, including while en=0.
//   Latency: 0 cycles on match, 1 cycle on match_q and match_count.
// TESTING
//   1. Overlap: len=4, pattern=4'b1101, ovl=1, x=1,1,0,1,1,0,1 (en=1) -> match on bits 4 and 7; count=2.
//   2. Non-overlap: same stimulus, ovl=0 -> match on bit 4 only; count=1.
//   3. Enable gaps: pattern 1101 with en=0 cycles between bits (x toggles while en=0) -> single match on the 4th valid bit; no match while en=0.
//   4. Len 1 / len 0: len=1, pattern=1, x=1,0,1,1 -> match on bits 1,3,4. Then len=0 -> match never asserts.
//   5. Saturation: CNT_W=8, len=1, x=1 for 300 cycles -> count=255, count_sat=1. Then clr_count -> 0,0. clr with simultaneous match -> 0.
//   6. Reset / reload mid-stream: rst=0 after x=1,1,0 -> all outputs 0 immediately; next 1 gives no match. Repeat with cfg_load instead of rst -> history flushed, no match.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Signal bundle for the programmable serial-pattern detector.
// The master side configures the detector and feeds samples; the slave side is the detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               en;
    logic               x;
    logic               clr_count;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, en, x, clr_count,
        input  match, match_q, match_count, count_sat
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, en, x, clr_count,
        output match, match_q, match_count, count_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy detector for a 1-bit serial stream, with overlap
// control, a sample qualifier, a saturating match counter and a registered match copy.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Configuration registers
    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               ovl_reg;
    logic [LEN_W-1:0]   len_clamped;

    // The oldest of MAX_LEN history bits can never take part in a comparison
    // (the live x supplies the last bit), so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] hist_reg;
    logic [MAX_LEN-2:0] hist_next;
    logic [LEN_W-1:0]   fill_reg;
    logic [LEN_W-1:0]   fill_next;

    // Match datapath
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] bit_ok;
    logic [LEN_W-1:0]   len_m1;
    logic               pat_eq;
    logic               fill_ok;
    logic               match;

    // Output registers
    logic               match_q_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               sat_reg;
    logic               sat_next;

    assign len_clamped = (bus.cfg_len > MAX_LEN_L) ? MAX_LEN_L : bus.cfg_len;

    assign cand = {hist_reg, bus.x};

    // Per-bit compare; bits at or above the programmed length always agree.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
            assign bit_ok[gi] = (len_reg <= LEN_W'(gi)) || (cand[gi] == pat_reg[gi]);
        end
    endgenerate

    assign pat_eq  = &bit_ok;
    assign len_m1  = len_reg - 1'b1;
    assign fill_ok = (fill_reg >= len_m1);

    // Forced low during reset and during a configuration load.
    assign match = rst & ~bus.cfg_load & bus.en & (len_reg != '0) & fill_ok & pat_eq;

    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        if (bus.cfg_load) begin
            hist_next = '0;
            fill_next = '0;
        end else if (bus.en) begin
            hist_next = cand[MAX_LEN-2:0];
            if (match && !ovl_reg) begin
                fill_next = '0;
            end else if (fill_reg < MAX_LEN_L) begin
                fill_next = fill_reg + 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        sat_next   = sat_reg;
        if (bus.clr_count) begin
            count_next = '0;
            sat_next   = 1'b0;
        end else if (match && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
            if (count_reg == CNT_MAX - 1'b1) begin
                sat_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg     <= '0;
            len_reg     <= '0;
            ovl_reg     <= 1'b1;
            hist_reg    <= '0;
            fill_reg    <= '0;
            match_q_reg <= 1'b0;
            count_reg   <= '0;
            sat_reg     <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                pat_reg <= bus.cfg_pattern;
                len_reg <= len_clamped;
                ovl_reg <= bus.cfg_overlap;
            end
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            match_q_reg <= match;
            count_reg   <= count_next;
            sat_reg     <= sat_next;
        end
    end

    assign bus.match       = match;
    assign bus.match_q     = match_q_reg;
    assign bus.match_count = count_reg;
    assign bus.count_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scenario bench for seq_detector_param: expected match values are queued as
// stimulus is driven and checked (with match_q) by a monitor on the falling edge.
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic sb[$];
    logic prev_exp   = 1'b0;
    bit   prev_valid = 1'b0;

    // Scoreboard monitor: one queued entry per driven cycle.
    always @(negedge clk) begin
        logic exp_m;
        if (sb.size() > 0) begin
            exp_m = sb.pop_front();
            n_checks++;
            if (bus.match !== exp_m) begin
                n_fail++;
                $display("FAIL match @%0t: got %0b expected %0b", $time, bus.match, exp_m);
            end
            if (prev_valid) begin
                n_checks++;
                if (bus.match_q !== prev_exp) begin
                    n_fail++;
                    $display("FAIL match_q @%0t: got %0b expected %0b", $time, bus.match_q, prev_exp);
                end
            end
            prev_exp   = exp_m;
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic drive(input logic e, input logic xv, input logic c, input logic em);
        @(posedge clk);
        #1;
        bus.cfg_load  = 1'b0;
        bus.en        = e;
        bus.x         = xv;
        bus.clr_count = c;
        sb.push_back(em);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic e, input logic xv);
        @(posedge clk);
        #1;
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.en          = e;
        bus.x           = xv;
        bus.clr_count   = 1'b0;
        sb.push_back(1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = 8'hFF;
        bus.cfg_len     = 4'd1;
        bus.cfg_overlap = 1'b1;
        bus.en          = 1'b1;
        bus.x           = 1'b1;
        bus.clr_count   = 1'b0;
        #2;
        n_checks++;
        if (bus.match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0b expected 0", bus.match); end
        n_checks++;
        if (bus.match_q !== 1'b0) begin n_fail++; $display("FAIL reset_match_q: got %0b expected 0", bus.match_q); end
        n_checks++;
        if (bus.match_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.match_count); end
        n_checks++;
        if (bus.count_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b expected 0", bus.count_sat); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        // Detector is off after reset (len=0), so valid samples never match.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_overlap();
        logic xs[7] = '{1, 1, 0, 1, 1, 0, 1};
        logic es[7] = '{0, 0, 0, 1, 0, 0, 1};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, xs[i], 1'b0, es[i]);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd2) begin n_fail++; $display("FAIL overlap_count: got %0d expected 2", bus.match_count); end
    endtask

    task automatic test_non_overlap();
        logic xs[7] = '{1, 1, 0, 1, 1, 0, 1};
        logic es[7] = '{0, 0, 0, 1, 0, 0, 0};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b1101, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, xs[i], 1'b0, es[i]);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_count: got %0d expected 1", bus.match_count); end
    endtask

    task automatic test_enable_gaps();
        logic ens[10] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
        logic xs[10]  = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0};
        logic es[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(ens[i], xs[i], 1'b0, es[i]);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd1) begin n_fail++; $display("FAIL gaps_count: got %0d expected 1", bus.match_count); end
    endtask

    task automatic test_len1_len0();
        logic xs[4] = '{1, 0, 1, 1};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, xs[i], 1'b0, xs[i]);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd3) begin n_fail++; $display("FAIL len1_count: got %0d expected 3", bus.match_count); end
        load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd3) begin n_fail++; $display("FAIL len0_count: got %0d expected 3", bus.match_count); end
    endtask

    task automatic test_len_clamp_mask();
        logic [7:0] pat8 = 8'b10110011;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        // Length 15 clamps to 8: all eight pattern bits must be seen.
        load(pat8, 4'd15, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) drive(1'b1, pat8[i], 1'b0, (i == 0) ? 1'b1 : 1'b0);
        // Length 3: upper pattern bits are don't-care.
        load(8'b11111101, 4'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd2) begin n_fail++; $display("FAIL clamp_mask_count: got %0d expected 2", bus.match_count); end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d expected 255", bus.match_count); end
        n_checks++;
        if (bus.count_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %0b expected 1", bus.count_sat); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", bus.match_count); end
        n_checks++;
        if (bus.count_sat !== 1'b0) begin n_fail++; $display("FAIL clr_sat: got %0b expected 0", bus.count_sat); end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd0) begin n_fail++; $display("FAIL clr_vs_match_count: got %0d expected 0", bus.match_count); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd1) begin n_fail++; $display("FAIL post_clr_count: got %0d expected 1", bus.match_count); end
        n_checks++;
        if (bus.count_sat !== 1'b0) begin n_fail++; $display("FAIL post_clr_sat: got %0b expected 0", bus.count_sat); end
    endtask

    task automatic test_back_to_back();
        logic xs[6] = '{1, 1, 0, 1, 1, 0};
        logic es[6] = '{0, 0, 0, 1, 0, 0};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, xs[i], 1'b0, es[i]);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.match_count !== 8'd1) begin n_fail++; $display("FAIL pre_rst_count: got %0d expected 1", bus.match_count); end
        // Asynchronous reset with a sample that would otherwise complete 1101.
        bus.en = 1'b1;
        bus.x  = 1'b1;
        rst    = 1'b0;
        #1;
        n_checks++;
        if (bus.match !== 1'b0) begin n_fail++; $display("FAIL rst_match: got %0b expected 0", bus.match); end
        n_checks++;
        if (bus.match_q !== 1'b0) begin n_fail++; $display("FAIL rst_match_q: got %0b expected 0", bus.match_q); end
        n_checks++;
        if (bus.match_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", bus.match_count); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        // Reload mid-stream: cfg_load beats en and flushes history.
        load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        load(8'b1101, 4'd4, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        n_checks++;
        if (bus.match_count !== 8'd1) begin n_fail++; $display("FAIL reload_count: got %0d expected 1", bus.match_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_enable_gaps();
        test_len1_len0();
        test_len_clamp_mask();
        test_saturation();
        test_back_to_back();
        idle(2);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
